du_tx_arbiter: RTL and testbench

Shares the debug unit's single UART transmit path (TX FIFO write port plus TX start/done handshake) between up to `N_REQ` debug-unit transmitters, such as the register-file dump, the data-memory dump and the status reporter. It grants one requester at a time and starts it with a one-cycle pulse. While a requester holds the grant, the block muxes that requester's write/start/data onto the UART and routes the UART done back to it only. The grant is released only after the requester signals end of transaction and its final byte has completed.

---
 rtl/du_tx_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_du_tx_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/du_tx_arbiter.sv
// du_tx_arbiter
//
// Shares the debug unit's single UART transmit path between N_REQ
// transmitters. Examples are the register-file dump, the data-memory dump
// and the status reporter. One requester is granted at a time. It is
// started with a one-cycle pulse. While it holds the grant, its
// write/start/data are muxed onto the UART, and the UART done is routed
// back to it alone. The grant is released only when the requester flags
// end of transaction together with the completion of its final byte.
// A dead cycle (RELEASE) follows before any new grant.
//
// Configuration macro:
//   DU_TX_ARB_RR_EN  defined   -> round-robin arbitration, starting after
//                                 the last released requester
//                    undefined -> fixed priority, lowest index wins
//
// Ports:
//   clk          clock
//   i_rst        synchronous active-high reset
//   i_req        per-requester level request
//   i_done       per-requester end-of-transaction level
//   i_wr         per-requester TX FIFO write enable
//   i_tx_start   per-requester UART TX start
//   i_wdata      packed per-requester write data, requester k at [k*W +: W]
//   i_tx_done    UART TX done
//   o_gnt        registered one-hot grant
//   o_start      one-cycle start pulse to the granted requester
//   o_tx_done    i_tx_done routed to the granted requester only
//   o_wr         muxed FIFO write enable
//   o_tx_start   muxed TX start
//   o_wdata      muxed write data
//   o_busy       high while a requester owns the path (START/ACTIVE)
//
// State | meaning
// ------+------------------------------------------------------------
// IDLE    | no grant; arbitrate among pending requests
// START   | grant issued; start pulse to the winner; mux live
// ACTIVE  | mux live; wait for done[gnt] together with tx_done
// RELEASE | grant dropped; dead cycle so the requester can settle

module du_tx_arbiter #(
    parameter int NB_UART_DATA = 8,
    parameter int N_REQ        = 3,
    parameter int NB_IDX       = 3
) (
    input  logic                          clk,
    input  logic                          i_rst,
    input  logic [N_REQ-1:0]              i_req,
    input  logic [N_REQ-1:0]              i_done,
    input  logic [N_REQ-1:0]              i_wr,
    input  logic [N_REQ-1:0]              i_tx_start,
    input  logic [N_REQ*NB_UART_DATA-1:0] i_wdata,
    input  logic                          i_tx_done,
    output logic [N_REQ-1:0]              o_gnt,
    output logic [N_REQ-1:0]              o_start,
    output logic [N_REQ-1:0]              o_tx_done,
    output logic                          o_wr,
    output logic                          o_tx_start,
    output logic [NB_UART_DATA-1:0]       o_wdata,
    output logic                          o_busy
);

    if (NB_IDX < $clog2(N_REQ)) begin : g_idx_check
        $error("du_tx_arbiter: NB_IDX too narrow for N_REQ");
    end

    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        START   = 4'b0010,
        ACTIVE  = 4'b0100,
        RELEASE = 4'b1000
    } state_t;

    state_t           state, state_nxt;
    logic [N_REQ-1:0] gnt_reg, gnt_nxt;
    logic [N_REQ-1:0] winner;
    logic             done_hit;

    // Isolate the lowest set bit: v & (two's complement of v).
    function automatic logic [N_REQ-1:0] lowest_set(input logic [N_REQ-1:0] v);
        return v & (~v + N_REQ'(1));
    endfunction

`ifdef DU_TX_ARB_RR_EN
    logic [NB_IDX-1:0] last_reg, last_nxt;
    logic [NB_IDX-1:0] gnt_idx;
    logic [N_REQ-1:0]  above_last;
    logic [N_REQ-1:0]  req_hi;

    // Round robin: prefer requests strictly above the last owner. If there
    // are none, the search wraps to the lowest pending request.
    always_comb begin
        above_last = '0;
        for (int k = 0; k < N_REQ; k++) begin
            above_last[k] = (k > int'(last_reg));
        end
        req_hi = i_req & above_last;
        winner = (|req_hi) ? lowest_set(req_hi) : lowest_set(i_req);
    end

    always_comb begin
        gnt_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt_reg[k]) gnt_idx = NB_IDX'(k);
        end
    end
`else
    always_comb begin
        winner = lowest_set(i_req);
    end
`endif

    // Only the granted requester's done counts.
    assign done_hit = |(i_done & gnt_reg);

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state   <= IDLE;
            gnt_reg <= '0;
`ifdef DU_TX_ARB_RR_EN
            last_reg <= NB_IDX'(N_REQ - 1);
`endif
        end else begin
            state   <= state_nxt;
            gnt_reg <= gnt_nxt;
`ifdef DU_TX_ARB_RR_EN
            last_reg <= last_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt_reg;
`ifdef DU_TX_ARB_RR_EN
        last_nxt  = last_reg;
`endif
        case (state)
            IDLE: begin
                if (|i_req) begin
                    gnt_nxt   = winner;
                    state_nxt = START;
                end
            end
            START: begin
                state_nxt = ACTIVE;
            end
            ACTIVE: begin
                if (done_hit && i_tx_done) begin
                    gnt_nxt   = '0;
                    state_nxt = RELEASE;
`ifdef DU_TX_ARB_RR_EN
                    last_nxt  = gnt_idx;
`endif
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            default: begin
                gnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // AND-OR mux over the one-hot grant. With no grant, everything is zero.
    always_comb begin
        o_wdata = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt_reg[k]) o_wdata = o_wdata | i_wdata[k*NB_UART_DATA +: NB_UART_DATA];
        end
    end

    assign o_wr       = |(i_wr & gnt_reg);
    assign o_tx_start = |(i_tx_start & gnt_reg);
    assign o_tx_done  = gnt_reg & {N_REQ{i_tx_done}};
    assign o_gnt      = gnt_reg;
    assign o_start    = (state == START) ? gnt_reg : '0;
    assign o_busy     = (state == START) || (state == ACTIVE);

endmodule

// File: tb/tb_du_tx_arbiter.sv
module tb_du_tx_arbiter;

    localparam int W = 8;
    localparam int N = 3;

    logic           clk = 1'b0;
    logic           i_rst;
    logic [N-1:0]   i_req, i_done, i_wr, i_tx_start;
    logic [N*W-1:0] i_wdata;
    logic           i_tx_done;
    logic [N-1:0]   o_gnt, o_start, o_tx_done;
    logic           o_wr, o_tx_start, o_busy;
    logic [W-1:0]   o_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    du_tx_arbiter #(.NB_UART_DATA(W), .N_REQ(N), .NB_IDX(3)) dut (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_req      (i_req),
        .i_done     (i_done),
        .i_wr       (i_wr),
        .i_tx_start (i_tx_start),
        .i_wdata    (i_wdata),
        .i_tx_done  (i_tx_done),
        .o_gnt      (o_gnt),
        .o_start    (o_start),
        .o_tx_done  (o_tx_done),
        .o_wr       (o_wr),
        .o_tx_start (o_tx_start),
        .o_wdata    (o_wdata),
        .o_busy     (o_busy)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Advance one clock; inputs are changed just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #1;
    endtask

    task automatic check_quiet(input string tag);
        settle();
        check_val({tag, " gnt"},     32'(o_gnt), 32'h0);
        check_val({tag, " start"},   32'(o_start), 32'h0);
        check_val({tag, " busy"},    32'(o_busy), 32'h0);
        check_val({tag, " wr"},      32'(o_wr), 32'h0);
        check_val({tag, " txstart"}, 32'(o_tx_start), 32'h0);
        check_val({tag, " wdata"},   32'(o_wdata), 32'h0);
        check_val({tag, " txdone"},  32'(o_tx_done), 32'h0);
    endtask

    // Starts in an IDLE cycle with i_req held. Runs one short grant and ends
    // back in IDLE.
    task automatic run_grant(input string tag, input logic [N-1:0] exp_g);
        step();
        settle();
        check_val({tag, " gnt"},   32'(o_gnt), 32'(exp_g));
        check_val({tag, " start"}, 32'(o_start), 32'(exp_g));
        step();
        i_done    = exp_g;
        i_tx_done = 1'b1;
        step();
        i_done    = '0;
        i_tx_done = 1'b0;
        settle();
        check_val({tag, " rel gnt"}, 32'(o_gnt), 32'h0);
        step();
        settle();
        check_val({tag, " idle busy"}, 32'(o_busy), 32'h0);
    endtask

    initial begin
        i_rst      = 1'b1;
        i_req      = 3'b111;
        i_done     = '0;
        i_wr       = '0;
        i_tx_start = '0;
        i_wdata    = '0;
        i_tx_done  = 1'b0;

        // Reset held with all requests pending.
        step();
        step();
        check_quiet("reset");
        i_rst = 1'b0;
        step();
        settle();
        check_val("post-rst gnt",   32'(o_gnt), 32'h1);
        check_val("post-rst start", 32'(o_start), 32'h1);
        check_val("post-rst busy",  32'(o_busy), 32'h1);
        i_req = '0;
        step();
        settle();
        check_val("active start clr", 32'(o_start), 32'h0);
        check_val("active gnt",       32'(o_gnt), 32'h1);
        i_done    = 3'b001;
        i_tx_done = 1'b1;
        settle();
        check_val("release-cycle txdone", 32'(o_tx_done), 32'h1);
        step();
        settle();
        check_val("release gnt",    32'(o_gnt), 32'h0);
        check_val("release txdone", 32'(o_tx_done), 32'h0);
        check_val("release busy",   32'(o_busy), 32'h0);
        i_done    = '0;
        i_tx_done = 1'b0;
        step();

        // Single transaction by requester 1, bytes A5 then 3C.
        i_req = 3'b010;
        step();
        settle();
        check_val("t2 gnt",   32'(o_gnt), 32'h2);
        check_val("t2 start", 32'(o_start), 32'h2);
        i_req = '0;
        step();
        i_wr            = 3'b010;
        i_tx_start      = 3'b010;
        i_wdata[W +: W] = 8'hA5;
        settle();
        check_val("t2 b0 wdata",   32'(o_wdata), 32'hA5);
        check_val("t2 b0 wr",      32'(o_wr), 32'h1);
        check_val("t2 b0 txstart", 32'(o_tx_start), 32'h1);
        step();
        i_wr       = '0;
        i_tx_start = '0;
        i_tx_done  = 1'b1;
        settle();
        check_val("t2 b0 txdone", 32'(o_tx_done), 32'h2);
        check_val("t2 b0 wr off", 32'(o_wr), 32'h0);
        step();
        i_tx_done       = 1'b0;
        i_wr            = 3'b010;
        i_tx_start      = 3'b010;
        i_wdata[W +: W] = 8'h3C;
        settle();
        check_val("t2 b1 wdata",   32'(o_wdata), 32'h3C);
        check_val("t2 b1 txstart", 32'(o_tx_start), 32'h1);
        step();
        i_wr       = '0;
        i_tx_start = '0;
        i_tx_done  = 1'b1;
        i_done     = 3'b010;
        settle();
        check_val("t2 b1 txdone", 32'(o_tx_done), 32'h2);
        step();
        settle();
        check_val("t2 rel gnt",   32'(o_gnt), 32'h0);
        check_val("t2 rel wdata", 32'(o_wdata), 32'h0);
        check_val("t2 rel busy",  32'(o_busy), 32'h0);
        i_tx_done = 1'b0;
        i_done    = '0;
        i_wdata   = '0;
        step();
        settle();
        check_val("t2 idle gnt", 32'(o_gnt), 32'h0);

        // Done held without tx_done keeps the grant.
        i_req = 3'b001;
        step();
        settle();
        check_val("t3 gnt", 32'(o_gnt), 32'h1);
        i_req = '0;
        step();
        i_done = 3'b001;
        for (int i = 0; i < 5; i++) begin
            step();
            settle();
            check_val("t3 held gnt",  32'(o_gnt), 32'h1);
            check_val("t3 held busy", 32'(o_busy), 32'h1);
        end
        i_tx_done = 1'b1;
        step();
        settle();
        check_val("t3 rel gnt", 32'(o_gnt), 32'h0);
        i_done    = '0;
        i_tx_done = 1'b0;
        step();

        // Isolation: requester 2 drives junk while requester 0 owns the path.
        i_req = 3'b001;
        step();
        settle();
        check_val("t5 gnt", 32'(o_gnt), 32'h1);
        i_req = 3'b100;
        step();
        i_wr              = 3'b101;
        i_wdata[0 +: W]   = 8'h5A;
        i_wdata[2*W +: W] = 8'hFF;
        i_done            = 3'b100;
        i_tx_done         = 1'b1;
        settle();
        check_val("t5 wdata",  32'(o_wdata), 32'h5A);
        check_val("t5 txdone", 32'(o_tx_done), 32'h1);
        step();
        i_wr = 3'b100;
        settle();
        check_val("t5 foreign done gnt", 32'(o_gnt), 32'h1);
        check_val("t5 foreign wr",       32'(o_wr), 32'h0);
        i_wr   = '0;
        i_done = 3'b001;
        step();
        i_done    = '0;
        i_tx_done = 1'b0;
        i_wdata   = '0;
        i_req     = '0;
        step();

        // Arbitration order with all requests held, starting from reset.
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        i_req = 3'b111;
`ifdef DU_TX_ARB_RR_EN
        run_grant("rr0", 3'b001);
        run_grant("rr1", 3'b010);
        run_grant("rr2", 3'b100);
        run_grant("rr3", 3'b001);
`else
        run_grant("fp0", 3'b001);
        run_grant("fp1", 3'b001);
        run_grant("fp2", 3'b001);
        run_grant("fp3", 3'b001);
`endif

        // Reset in the middle of a 4-byte transaction, after 2 bytes.
        i_req = 3'b001;
        step();
        settle();
        check_val("t6 gnt", 32'(o_gnt), 32'h1);
        i_req = '0;
        step();
        for (int b = 0; b < 2; b++) begin
            i_wr       = 3'b001;
            i_tx_start = 3'b001;
            step();
            i_wr       = '0;
            i_tx_start = '0;
            i_tx_done  = 1'b1;
            step();
            i_tx_done  = 1'b0;
        end
        i_rst      = 1'b1;
        i_wr       = 3'b001;
        i_tx_start = 3'b001;
        i_wdata    = 24'h0000C3;
        step();
        check_quiet("t6 rst");
        i_rst      = 1'b0;
        i_wr       = '0;
        i_tx_start = '0;
        i_wdata    = '0;
        i_req      = 3'b100;
        step();
        settle();
        check_val("t6 new gnt",   32'(o_gnt), 32'h4);
        check_val("t6 new start", 32'(o_start), 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
